// File: rtl/max_pool_3x3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : max_pool_3x3_pkg
//  Purpose  : Shared constants for the 3x3 FP16 max-pool reducer and the
//             sign-magnitude ordering helper used by every max2 node.
//  Revision : 1.0  initial release
// ============================================================================
package max_pool_3x3_pkg;

  localparam int NN_WIDTH        = 16;
  localparam int POOL_WINDOW     = 9;
  localparam int NH_VECTOR_WIDTH = NN_WIDTH * POOL_WINDOW;
  localparam int POOL_OUT_WIDTH  = NN_WIDTH;

  // binary16 field positions
  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_MSB  = 14;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_MAN_MSB  = 9;
  localparam int FP16_MAN_LSB  = 0;

  // True when a is greater than or equal to b in sign-magnitude order.
  // Both zeros (either sign) count as equal so the a-side is kept.
  function automatic logic fp16_a_wins(input logic [NN_WIDTH-1:0] a,
                                       input logic [NN_WIDTH-1:0] b);
    logic [FP16_EXP_MSB:0] mag_a;
    logic [FP16_EXP_MSB:0] mag_b;
    logic                  win;
    mag_a = a[FP16_EXP_MSB:0];
    mag_b = b[FP16_EXP_MSB:0];
    if ((mag_a == '0) && (mag_b == '0)) begin
      win = 1'b1;
    end else if (a[FP16_SIGN_BIT] != b[FP16_SIGN_BIT]) begin
      win = ~a[FP16_SIGN_BIT];
    end else if (!a[FP16_SIGN_BIT]) begin
      win = (mag_a >= mag_b);
    end else begin
      win = (mag_a <= mag_b);
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_pool_3x3_fp16_max2.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_max2
//  Purpose  : Combinational two-input FP16 maximum; returns a on a tie.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_max2
  import max_pool_3x3_pkg::*;
(
  input  logic [NN_WIDTH-1:0] a,
  input  logic [NN_WIDTH-1:0] b,
  output logic [NN_WIDTH-1:0] max_out
);

  assign max_out = fp16_a_wins(a, b) ? a : b;

endmodule
`default_nettype wire

// File: rtl/max_pool_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : max_pool_3x3
//  Purpose  : 3x3 FP16 max-pool reducer. Balanced tree 9->5->3->2->1 of
//             fp16_max2 nodes followed by an output register.
//             Build option MAX_POOL_PIPELINE_EN adds a register after the
//             second tree level (latency 2 instead of 1).
//  Revision : 1.0  initial release
// ============================================================================
module max_pool_3x3
  import max_pool_3x3_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ena,
  input  logic [NH_VECTOR_WIDTH-1:0] in_vector,
  output logic [POOL_OUT_WIDTH-1:0]  pool_out
);

  logic [NN_WIDTH-1:0] w_elem [POOL_WINDOW];
  logic [NN_WIDTH-1:0] w_l1   [5];
  logic [NN_WIDTH-1:0] w_l2   [3];
  logic [NN_WIDTH-1:0] w_l3_in [3];
  logic [NN_WIDTH-1:0] w_l3;
  logic [NN_WIDTH-1:0] w_max;

  generate
    for (genvar k = 0; k < POOL_WINDOW; k++) begin : g_unpack
      assign w_elem[k] = in_vector[k*NN_WIDTH +: NN_WIDTH];
    end

    // Level 1: four pairs, element 8 passes through unpaired
    for (genvar i = 0; i < 4; i++) begin : g_level1
      fp16_max2 u_max2 (
        .a       (w_elem[2*i]),
        .b       (w_elem[2*i+1]),
        .max_out (w_l1[i])
      );
    end
  endgenerate

  assign w_l1[4] = w_elem[8];

  // Level 2: two pairs, the element-8 path passes through
  fp16_max2 u_l2_0 (.a(w_l1[0]), .b(w_l1[1]), .max_out(w_l2[0]));
  fp16_max2 u_l2_1 (.a(w_l1[2]), .b(w_l1[3]), .max_out(w_l2[1]));
  assign w_l2[2] = w_l1[4];

`ifdef MAX_POOL_PIPELINE_EN
  logic [NN_WIDTH-1:0] r_l2 [3];

  // Mid-tree stage holding the three partial maxima
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 3; j++) r_l2[j] <= '0;
    end else if (ena) begin
      for (int j = 0; j < 3; j++) r_l2[j] <= w_l2[j];
    end
  end

  assign w_l3_in = r_l2;
`else
  assign w_l3_in = w_l2;
`endif

  // Levels 3 and 4: lower-index partial always on the a input
  fp16_max2 u_l3   (.a(w_l3_in[0]), .b(w_l3_in[1]), .max_out(w_l3));
  fp16_max2 u_l4   (.a(w_l3),       .b(w_l3_in[2]), .max_out(w_max));

  // Output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pool_out <= '0;
    end else if (ena) begin
      pool_out <= w_max;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_max_pool_3x3
//  Purpose  : Self-checking bench for max_pool_3x3 (table vectors, scoreboard
//             queue, hold / reset corner sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_max_pool_3x3;

`ifdef MAX_POOL_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         reset;
  logic         ena;
  logic [143:0] in_vector;
  logic [15:0]  pool_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_out;

  typedef struct {
    logic [143:0] window;
    logic [15:0]  expected;
    string        name;
  } vec_t;

  vec_t vecs[8];

  max_pool_3x3 dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_vector (in_vector),
    .pool_out  (pool_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Independent reference: map each value to a signed ordering key.
  function automatic int key_of(input logic [15:0] x);
    int m;
    m = int'(x[14:0]);
    if (m == 0) return 0;
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] ref_max(input logic [143:0] w);
    logic [15:0] best;
    logic [15:0] e;
    best = w[15:0];
    for (int k = 1; k < 9; k++) begin
      e = w[k*16 +: 16];
      if (key_of(e) > key_of(best)) best = e;
    end
    return best;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Drive one cycle, then update the scoreboard and compare.
  task automatic step(input logic [143:0] win, input logic en,
                      input logic rst_n, input logic [15:0] exp_v,
                      input string name);
    in_vector = win;
    ena       = en;
    reset     = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      last_out = 16'h0000;
      check({name, "_reset"}, pool_out, 16'h0000);
    end else if (en) begin
      exp_q.push_back(exp_v);
      if (exp_q.size() == LAT) begin
        last_out = exp_q.pop_front();
        check(name, pool_out, last_out);
      end else begin
        check({name, "_fill"}, pool_out, last_out);
      end
    end else begin
      check({name, "_hold"}, pool_out, last_out);
    end
  endtask

  task automatic flush(input string name);
    for (int i = 0; i < LAT - 1; i++) step('0, 1'b1, 1'b1, 16'h0000, name);
  endtask

  logic [143:0] w;
  logic [143:0] mixed;

  initial begin
    mixed = {16'h0000, 16'h4A40, 16'hCA40, 16'h4910, 16'h48A0,
             16'hC910, 16'hC8A0, 16'h0000, 16'h3C00};
    vecs[0] = '{mixed, 16'h4A40, "mixed"};
    vecs[1] = '{{16'h0000, 16'h4A40, 16'hCA40, 16'h4910, 16'h48A0,
                 16'hC910, 16'hC8A0, 16'h4CE0, 16'h3C00}, 16'h4CE0, "k1_19p5"};
    vecs[2] = '{{16'hC880, 16'hC800, 16'hC700, 16'hC600, 16'hC500,
                 16'hC400, 16'hC200, 16'hC000, 16'hBC00}, 16'hBC00, "all_neg"};
    vecs[3] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h8000}, 16'h8000, "negzero_k0"};
    vecs[4] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h8000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, "poszero_k0"};
    vecs[5] = '{{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'hBC00,
                 16'hC000, 16'hC200, 16'hC400, 16'hC500}, 16'h8000, "negzero_k5"};
    vecs[6] = '{{16'h7C00, 16'h7BFF, 16'h3C00, 16'h0001, 16'h4000,
                 16'h0000, 16'h5000, 16'h6000, 16'h7000}, 16'h7C00, "inf_k8"};
    vecs[7] = '{{16'hBC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00,
                 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, 16'hBC00, "neg_k8"};

    last_out  = 16'h0000;
    in_vector = '0;
    ena       = 1'b0;
    reset     = 1'b0;

    // Reset held two cycles with arbitrary input and ena high
    step(mixed, 1'b1, 1'b0, 16'h0000, "rst0");
    step({9{16'h7000}}, 1'b1, 1'b0, 16'h0000, "rst1");

    // Table vectors back-to-back, one result per enabled cycle
    for (int i = 0; i < 8; i++) step(vecs[i].window, 1'b1, 1'b1, vecs[i].expected, vecs[i].name);
    flush("tbl_flush");

    // Random windows checked against the reference model
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'($urandom);
      step(w, 1'b1, 1'b1, ref_max(w), "rand");
    end
    // Maximum placed at each index in turn among positives
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'h3C00 + 16'(k);
      w[p*16 +: 16] = 16'h5800;
      step(w, 1'b1, 1'b1, 16'h5800, "max_pos");
    end
    flush("rand_flush");

    // ena low for three cycles while the input keeps changing
    step(vecs[1].window, 1'b1, 1'b1, 16'h4CE0, "pre_hold");
    flush("pre_hold_flush");
    step(vecs[6].window, 1'b0, 1'b1, 16'h0000, "ena_off0");
    step(vecs[2].window, 1'b0, 1'b1, 16'h0000, "ena_off1");
    step(vecs[7].window, 1'b0, 1'b1, 16'h0000, "ena_off2");
    step(vecs[2].window, 1'b1, 1'b1, 16'hBC00, "reenable");
    flush("reenable_flush");

    // Reset mid-stream with ena high: no stale value afterwards
    step(vecs[6].window, 1'b1, 1'b1, 16'h7C00, "stream0");
    step(vecs[1].window, 1'b1, 1'b1, 16'h4CE0, "stream1");
    step(vecs[6].window, 1'b1, 1'b0, 16'h0000, "mid_rst");
    step(vecs[2].window, 1'b1, 1'b1, 16'hBC00, "post_rst0");
    step(vecs[0].window, 1'b1, 1'b1, 16'h4A40, "post_rst1");
    flush("post_rst_flush");

    // Reset with ena low still clears
    step(vecs[6].window, 1'b1, 1'b1, 16'h7C00, "pre_rst_off");
    flush("pre_rst_off_flush");
    step(vecs[6].window, 1'b0, 1'b0, 16'h0000, "rst_ena_off");
    step(vecs[6].window, 1'b0, 1'b1, 16'h0000, "after_rst_off");
    step(vecs[3].window, 1'b1, 1'b1, 16'h8000, "final");
    flush("final_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max_pool_3x3.md
# max_pool_3x3

RTL module `max_pool`: a 3×3 max-pooling reducer for the CNN datapath. Each enabled cycle it takes one 9-element window of FP16 activations, picks the largest, and registers it on `pool_out`. It sits after the neighbourhood (window) builder and before the pooled-feature-map writer.

## Interface
Parameters (shared header constants, not per-instance overrides):
- `NN_WIDTH`, 16, width of one FP16 element.
- `POOL_WINDOW`, 9, elements per window (3×3).
- `NH_VECTOR_WIDTH`, `NN_WIDTH*POOL_WINDOW` = 144, packed window width.
- `POOL_OUT_WIDTH`, `NN_WIDTH` = 16, result width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ena`  in  1  enable. While low, all pipeline registers hold.
- `in_vector`  in  144  packed window. Element k occupies bits `[16k+15:16k]`, k = 0..8.
- `pool_out`  out  16  registered FP16 maximum of the window.

## Operation
- Elements are IEEE-754 binary16: sign[15], exponent[14:10], mantissa[9:0].
- Comparison is sign-magnitude:
  - Any positive value is greater than any negative value.
  - Between two positives, the larger `[14:0]` wins.
  - Between two negatives, the smaller `[14:0]` wins.
  - +0 and −0 compare equal.
- Tie rule: on equality the lower-index element wins. So `max(+0, −0)` returns the bit pattern of whichever has the lower index.
- Infinities compare naturally. NaN inputs are out of contract: output is the bit-pattern result of the rules above, with no NaN propagation.
- The reduction is a balanced tree of 8 two-input max operations. Levels: 9→5→3→2→1. Element 8 passes through level 1 unpaired.
- The output is an exact copy of one input element. No rounding, no arithmetic.

## Timing
- Reset:
  - Applies on a rising edge with `reset`=0, regardless of `ena`.
  - Forces `pool_out` = 16'h0000 and clears any internal pipeline registers.
- Default build latency is 1 cycle: window sampled at edge N with `ena`=1 appears on `pool_out` after edge N.
- `ena`=0 at an edge: `pool_out` and internal registers keep their values. The input sampled at that edge is discarded.
- Throughput: one window per enabled cycle. There is no handshake or backpressure.
- Reset released mid-stream: the first valid output follows the first enabled edge after release. Pipelined build: after the second.
- Reset and `ena`=1 asserted together: reset wins.

## Configuration
- `MAX_POOL_PIPELINE_EN` defined:
  - Adds a register stage after tree level 2 (the 3 partial maxima), giving latency 2 cycles.
  - The stage is gated by `ena` and cleared by reset.
  - Data enters and leaves the stage together, so no bubbles are introduced.
- Not defined: purely combinational tree plus output register, latency 1.
- Functional results are identical in both builds; only latency differs.

## Structure
- Shared header `cnn_parameters.vh` holds `NN_WIDTH`, `POOL_WINDOW`, `NH_VECTOR_WIDTH` and `POOL_OUT_WIDTH`. The FP16 field positions (sign bit, exponent/mantissa ranges) belong there too.
- One sub-module, `fp16_max2`:
  - Combinational: inputs `a`, `b`; output is the max, returning `a` on a tie.
  - Instantiated 8 times, with the lower-index operand always on `a`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with arbitrary input → `pool_out`=16'h0000.
- Mixed window, elements k8..k0 = 0, 12.5, −12.5, 10.125, 9.25, −10.125, −9.25, 0, 1.0 (hex 0000, 4A40, CA40, 4910, 48A0, C910, C8A0, 0000, 3C00) with `ena`=1 → 16'h4A40 after the required latency.
- Same window but k1 = 19.5 (4CE0) → 16'h4CE0 on the next output; back-to-back windows yield one result per cycle.
- All negative (−1, −2, …, −9) → 16'hBC00 (−1.0). Mixed ±0 only, k0 = 8000 and k1..k8 = 0000 → 16'h8000 (tie picks lowest index).
- `ena` dropped for 3 cycles while the input changes → `pool_out` frozen. On re-enable, the new max appears after the required latency.
- `reset` asserted with `ena`=1 mid-stream → `pool_out`=0 on the next edge, and no stale pipeline value emerges afterwards (check in both builds).
